// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared Q-format limits and saturate/overflow helper for fixed-point blocks
package fixed_point_pkg;
  typedef struct packed {
    logic        ovf;
    logic [31:0] data;
  } fxp_res_t;

  function automatic logic [31:0] fxp_max(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] fxp_min(input int w);
    return 32'd1 << (w - 1);
  endfunction

  // sum holds a (w+1)-bit two's-complement value in its low bits; callers keep data[w-1:0]
  function automatic fxp_res_t fxp_sat(input logic [32:0] sum, input int w, input bit sat);
    fxp_res_t r;
    r.ovf  = sum[w] != sum[w-1];
    r.data = (r.ovf && sat) ? (sum[w] ? fxp_min(w) : fxp_max(w)) : sum[31:0];
    return r;
  endfunction
endpackage

// File: rtl/fixed_point_pipe_reg.sv
// fixed_point_pipe_reg: valid/ready register slice with full throughput
module fixed_point_pipe_reg #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end
endmodule

// File: rtl/fixed_point_addsub_pipe.sv
// fixed_point_addsub_pipe: two-stage signed fixed-point add/sub with saturate or wrap
module fixed_point_addsub_pipe
  import fixed_point_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int FRAC_W   = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sub,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_ovf,
  output logic              o_ovf_sticky,
  input  logic              i_ovf_clr
);
  logic [DATA_W:0]   w_a_ext, w_b_ext, w_sum, w_s1_sum;
  logic              w_s1_valid, w_s2_ready;
  fxp_res_t          w_res;
  logic              r_ovf_sticky;

  assign w_a_ext = {i_a[DATA_W-1], i_a};
  assign w_b_ext = {i_b[DATA_W-1], i_b};
  assign w_sum   = i_sub ? w_a_ext - w_b_ext : w_a_ext + w_b_ext;
  assign w_res   = fxp_sat(33'(w_s1_sum), DATA_W, SATURATE);

  fixed_point_pipe_reg #(.W(DATA_W + 1)) u_s1 (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(w_sum),
    .o_valid(w_s1_valid), .i_ready(w_s2_ready), .o_data(w_s1_sum)
  );

  fixed_point_pipe_reg #(.W(DATA_W + 1)) u_s2 (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_valid(w_s1_valid), .o_ready(w_s2_ready), .i_data({w_res.ovf, w_res.data[DATA_W-1:0]}),
    .o_valid(o_valid), .i_ready(i_ready), .o_data({o_ovf, o_data})
  );

  // set beats clear when an overflowed result lands in S2 on the clear cycle
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_ovf_sticky <= 1'b0;
    else r_ovf_sticky <= (w_s1_valid && w_s2_ready && w_res.ovf) ? 1'b1 : i_ovf_clr ? 1'b0 : r_ovf_sticky;
  end

  assign o_ovf_sticky = r_ovf_sticky;
endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// tb_fixed_point_addsub_pipe: directed checks of saturating and wrapping instances sharing one stimulus
module tb_fixed_point_addsub_pipe;
  logic       i_clk = 1'b0;
  logic       i_reset_n, i_valid, i_sub, i_ready, i_ovf_clr;
  logic [7:0] i_a, i_b;
  logic       s_ready, s_valid, s_ovf, s_sticky;
  logic       w_ready, w_valid, w_ovf, w_sticky;
  logic [7:0] s_data, w_data;
  int checks = 0, failures = 0;

  always #5 i_clk = ~i_clk;

  fixed_point_addsub_pipe #(.DATA_W(8), .FRAC_W(4), .SATURATE(1'b1)) dut_s (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(s_ready),
    .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .o_valid(s_valid), .i_ready(i_ready),
    .o_data(s_data), .o_ovf(s_ovf), .o_ovf_sticky(s_sticky), .i_ovf_clr(i_ovf_clr)
  );

  fixed_point_addsub_pipe #(.DATA_W(8), .FRAC_W(4), .SATURATE(1'b0)) dut_w (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(w_ready),
    .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .o_valid(w_valid), .i_ready(i_ready),
    .o_data(w_data), .o_ovf(w_ovf), .o_ovf_sticky(w_sticky), .i_ovf_clr(i_ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub);
    i_a = a; i_b = b; i_sub = sub; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub, input bit sat);
    int s;
    logic [7:0] lo;
    s  = sub ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
    lo = s[7:0];
    if (s > 127) return {1'b1, sat ? 8'h7F : lo};
    if (s < -128) return {1'b1, sat ? 8'h80 : lo};
    return {1'b0, lo};
  endfunction

  task automatic chk_res(input string tag, input logic [7:0] es, input logic eos, input logic [7:0] ew, input logic eow);
    chk({tag, "_vs"}, s_valid, 1'b1);
    chk({tag, "_ds"}, s_data, es);
    chk({tag, "_os"}, s_ovf, eos);
    chk({tag, "_dw"}, w_data, ew);
    chk({tag, "_ow"}, w_ovf, eow);
  endtask

  logic [7:0] sa[16], sb[16];
  logic       ss[16];
  logic [8:0] es, ew;

  initial begin
    i_reset_n = 1'b0; i_valid = 1'b0; i_sub = 1'b0; i_ready = 1'b1; i_ovf_clr = 1'b0;
    i_a = '0; i_b = '0;
    tick(); tick();
    chk("rst_valid", s_valid, 1'b0);
    chk("rst_data", s_data, 8'h00);
    chk("rst_ovf", s_ovf, 1'b0);
    chk("rst_sticky", s_sticky, 1'b0);
    chk("rst_ready", s_ready, 1'b1);
    i_reset_n = 1'b1;
    tick();

    send(8'h30, 8'h20, 1'b0); tick();
    chk_res("add", 8'h50, 1'b0, 8'h50, 1'b0);
    chk("add_sticky", s_sticky, 1'b0);
    tick();
    chk("bubble", s_valid, 1'b0);

    send(8'h70, 8'h20, 1'b0); tick();
    chk_res("posovf", 8'h7F, 1'b1, 8'h90, 1'b1);
    chk("posovf_sticky", s_sticky, 1'b1);
    send(8'h80, 8'h01, 1'b1); tick();
    chk_res("negovf", 8'h80, 1'b1, 8'h7F, 1'b1);
    send(8'h00, 8'h80, 1'b1); tick();
    chk_res("zero_min", 8'h7F, 1'b1, 8'h80, 1'b1);
    send(8'h80, 8'h80, 1'b1); tick();
    chk_res("min_min", 8'h00, 1'b0, 8'h00, 1'b0);
    send(8'h7F, 8'h7F, 1'b0); tick();
    chk_res("max_max", 8'h7F, 1'b1, 8'hFE, 1'b1);
    i_ovf_clr = 1'b1; tick(); i_ovf_clr = 1'b0;
    chk("clr_s", s_sticky, 1'b0);
    chk("clr_w", w_sticky, 1'b0);

    send(8'h70, 8'h20, 1'b0);
    i_ovf_clr = 1'b1; tick(); i_ovf_clr = 1'b0;
    chk("set_wins", s_sticky, 1'b1);
    tick();

    // backpressure: two accepted, third stalls until downstream frees up
    i_ready = 1'b0;
    i_a = 8'h01; i_b = 8'h02; i_sub = 1'b0; i_valid = 1'b1;
    #1 chk("bp_rdy1", s_ready, 1'b1);
    tick();
    i_a = 8'h10; i_b = 8'h05; i_sub = 1'b1;
    #1 chk("bp_rdy2", s_ready, 1'b1);
    tick();
    i_a = 8'h7F; i_b = 8'h01; i_sub = 1'b0;
    #1 chk("bp_rdy3", s_ready, 1'b0);
    chk("bp_hold0", s_data, 8'h03);
    tick();
    chk("bp_rdy3b", w_ready, 1'b0);
    chk("bp_hold1", s_data, 8'h03);
    chk("bp_valid", s_valid, 1'b1);
    i_ready = 1'b1;
    #1 chk("bp_rdy_comb", s_ready, 1'b1);
    tick();
    i_valid = 1'b0;
    chk_res("bp_r2", 8'h0B, 1'b0, 8'h0B, 1'b0);
    tick();
    chk_res("bp_r3", 8'h7F, 1'b1, 8'h80, 1'b1);
    tick();
    chk("bp_drain", s_valid, 1'b0);

    for (int k = 0; k < 16; k++) begin
      sa[k] = 8'($urandom); sb[k] = 8'($urandom); ss[k] = 1'($urandom);
    end
    sa[3] = 8'h7F; sb[3] = 8'h7F; ss[3] = 1'b0;
    sa[7] = 8'h00; sb[7] = 8'h80; ss[7] = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) begin
        i_a = sa[k]; i_b = sb[k]; i_sub = ss[k]; i_valid = 1'b1;
      end else i_valid = 1'b0;
      tick();
      if (k >= 1) begin
        es = model(sa[k-1], sb[k-1], ss[k-1], 1'b1);
        ew = model(sa[k-1], sb[k-1], ss[k-1], 1'b0);
        chk_res($sformatf("stream%0d", k - 1), es[7:0], es[8], ew[7:0], ew[8]);
      end
    end
    tick();
    chk("stream_drain", s_valid, 1'b0);

    i_a = 8'h11; i_b = 8'h22; i_sub = 1'b0; i_valid = 1'b1;
    tick();
    i_a = 8'h70; i_b = 8'h70;
    tick();
    i_valid = 1'b0;
    i_reset_n = 1'b0;
    tick();
    chk("rst_mid_valid", s_valid, 1'b0);
    chk("rst_mid_sticky", s_sticky, 1'b0);
    i_reset_n = 1'b1;
    tick();
    chk("rst_no_stale", s_valid, 1'b0);
    chk("rst_no_stale_w", w_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
